rq_offset_record: RTL and testbench

- Per-QP receive-queue consumer-offset table. Offsets are held in 16-byte units.
- The RQ metadata stage reads it through a 1-cycle-latency read port to compute the WQE prefetch address. It computes `offset*16`.
- Downstream WQE-consume logic advances the offset after WQEs are consumed. The QP-management path clears an entry on QP create/destroy.
- Both updates run through a 2-stage read-modify-write pipeline with forwarding. The block sweeps-clears the whole table after reset.

---
 rtl/rq_offset_record.sv | 218 +++++++++++++++++++++
 tb/tb_rq_offset_record.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rq_offset_record.sv
`default_nettype none
// ============================================================================
// Module   : rq_offset_record
// Brief    : Per-QP RQ consumer-offset table (16-byte units) with a 2-stage
//            forwarded RMW update path and a registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module rq_offset_record #(
    parameter int QP_NUM_LOG   = 14,
    parameter int OFFSET_WIDTH = 24,
    parameter int STEP_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [QP_NUM_LOG-1:0]   rq_offset_addr,
    output logic [OFFSET_WIDTH-1:0] rq_offset_dout,
    input  logic                    consume_valid,
    input  logic [QP_NUM_LOG-1:0]   consume_qpn,
    input  logic [STEP_WIDTH-1:0]   consume_num,
    input  logic [4:0]              consume_qdepth_log,
    output logic                    consume_ready,
    input  logic                    clr_valid,
    input  logic [QP_NUM_LOG-1:0]   clr_qpn,
    output logic                    clr_ready,
    output logic                    upd_valid,
    output logic [QP_NUM_LOG-1:0]   upd_qpn,
    output logic [OFFSET_WIDTH-1:0] upd_offset,
    output logic                    upd_wrap,
    output logic                    init_done
);

    localparam int c_DEPTH = 1 << QP_NUM_LOG;
    localparam logic [OFFSET_WIDTH:0] c_ONE = {{OFFSET_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        INIT_s = 1'b0,
        RUN_s  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_run;
    logic [QP_NUM_LOG-1:0]   r_init_cnt;

    logic [OFFSET_WIDTH-1:0] r_table [0:c_DEPTH-1];

    logic                    w_clr_acc;
    logic                    w_con_acc;
    logic                    w_acc;
    logic [QP_NUM_LOG-1:0]   w_acc_qpn;
    logic                    w_hit;

    logic                    r_s2_valid;
    logic                    r_s2_clr;
    logic [QP_NUM_LOG-1:0]   r_s2_qpn;
    logic [STEP_WIDTH-1:0]   r_s2_num;
    logic [4:0]              r_s2_qd;
    logic [OFFSET_WIDTH-1:0] r_s2_base;

    logic [OFFSET_WIDTH:0]   w_sum;
    logic [OFFSET_WIDTH:0]   w_lim;
    logic [OFFSET_WIDTH:0]   w_mask;
    logic [OFFSET_WIDTH-1:0] w_new;
    logic                    w_wrap;

    logic                    w_we;
    logic [QP_NUM_LOG-1:0]   w_waddr;
    logic [OFFSET_WIDTH-1:0] w_wdata;

    logic [OFFSET_WIDTH-1:0] r_dout;
    logic                    r_upd_valid;
    logic [QP_NUM_LOG-1:0]   r_upd_qpn;
    logic [OFFSET_WIDTH-1:0] r_upd_offset;
    logic                    r_upd_wrap;

    // ------------------------------------------------------------------------
    // Init sweep / run state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= INIT_s;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == INIT_s) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            INIT_s: begin
                if (r_init_cnt == {QP_NUM_LOG{1'b1}}) begin
                    w_state_nxt = RUN_s;
                end
            end
            RUN_s: begin
                w_run = 1'b1;
            end
            default: w_state_nxt = INIT_s;
        endcase
    end

    assign init_done     = w_run;
    assign clr_ready     = w_run;
    assign consume_ready = w_run & ~clr_valid;

    // ------------------------------------------------------------------------
    // S1: accept one op per cycle, read base (or forward the S2 result)
    // ------------------------------------------------------------------------
    assign w_clr_acc = clr_valid & clr_ready;
    assign w_con_acc = consume_valid & consume_ready;
    assign w_acc     = w_clr_acc | w_con_acc;
    assign w_acc_qpn = w_clr_acc ? clr_qpn : consume_qpn;
    // The table write of the op in S2 lands on the same edge as this read.
    assign w_hit     = r_s2_valid && (r_s2_qpn == w_acc_qpn);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_clr   <= 1'b0;
            r_s2_qpn   <= '0;
            r_s2_num   <= '0;
            r_s2_qd    <= '0;
            r_s2_base  <= '0;
        end else begin
            r_s2_valid <= w_acc;
            if (w_acc) begin
                r_s2_clr  <= w_clr_acc;
                r_s2_qpn  <= w_acc_qpn;
                r_s2_num  <= consume_num;
                r_s2_qd   <= consume_qdepth_log;
                r_s2_base <= w_hit ? w_new : r_table[w_acc_qpn];
            end
        end
    end

    // ------------------------------------------------------------------------
    // S2: compute new offset modulo the queue size
    // ------------------------------------------------------------------------
    assign w_sum  = {1'b0, r_s2_base} + {{(OFFSET_WIDTH + 1 - STEP_WIDTH){1'b0}}, r_s2_num};
    assign w_lim  = c_ONE << r_s2_qd;
    assign w_mask = w_lim - c_ONE;

    always_comb begin
        w_new  = '0;
        w_wrap = 1'b0;
        if (!r_s2_clr) begin
            if (r_s2_num == '0) begin
                w_new = r_s2_base;
            end else begin
                w_new  = w_sum[OFFSET_WIDTH-1:0] & w_mask[OFFSET_WIDTH-1:0];
                w_wrap = (w_sum >= w_lim);
            end
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_init_cnt;
        w_wdata = '0;
        if (r_state == INIT_s) begin
            w_we = 1'b1;
        end else if (r_s2_valid) begin
            w_we    = 1'b1;
            w_waddr = r_s2_qpn;
            w_wdata = w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_table[w_waddr] <= w_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Read port (write-first) and registered update report
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else if (!w_run) begin
            r_dout <= '0;
        end else if (r_s2_valid && (r_s2_qpn == rq_offset_addr)) begin
            r_dout <= w_new;
        end else begin
            r_dout <= r_table[rq_offset_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_valid  <= 1'b0;
            r_upd_qpn    <= '0;
            r_upd_offset <= '0;
            r_upd_wrap   <= 1'b0;
        end else begin
            r_upd_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_upd_qpn    <= r_s2_qpn;
                r_upd_offset <= w_new;
                r_upd_wrap   <= w_wrap;
            end
        end
    end

    assign rq_offset_dout = r_dout;
    assign upd_valid      = r_upd_valid;
    assign upd_qpn        = r_upd_qpn;
    assign upd_offset     = r_upd_offset;
    assign upd_wrap       = r_upd_wrap;

endmodule
`default_nettype wire

// File: tb/tb_rq_offset_record.sv
`default_nettype none
// ============================================================================
// Module   : tb_rq_offset_record
// Brief    : Directed self-checking bench for rq_offset_record.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rq_offset_record;

    localparam int QN = 14;
    localparam int OW = 24;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [QN-1:0] rq_offset_addr = '0;
    logic [OW-1:0] rq_offset_dout;
    logic          consume_valid = 1'b0;
    logic [QN-1:0] consume_qpn = '0;
    logic [SW-1:0] consume_num = '0;
    logic [4:0]    consume_qdepth_log = '0;
    logic          consume_ready;
    logic          clr_valid = 1'b0;
    logic [QN-1:0] clr_qpn = '0;
    logic          clr_ready;
    logic          upd_valid;
    logic [QN-1:0] upd_qpn;
    logic [OW-1:0] upd_offset;
    logic          upd_wrap;
    logic          init_done;

    int n_vec = 0;
    int n_err = 0;

    rq_offset_record #(
        .QP_NUM_LOG  (QN),
        .OFFSET_WIDTH(OW),
        .STEP_WIDTH  (SW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rq_offset_addr    (rq_offset_addr),
        .rq_offset_dout    (rq_offset_dout),
        .consume_valid     (consume_valid),
        .consume_qpn       (consume_qpn),
        .consume_num       (consume_num),
        .consume_qdepth_log(consume_qdepth_log),
        .consume_ready     (consume_ready),
        .clr_valid         (clr_valid),
        .clr_qpn           (clr_qpn),
        .clr_ready         (clr_ready),
        .upd_valid         (upd_valid),
        .upd_qpn           (upd_qpn),
        .upd_offset        (upd_offset),
        .upd_wrap          (upd_wrap),
        .init_done         (init_done)
    );

    always #5 clk = ~clk;

    // {upd_valid, upd_qpn, upd_offset, upd_wrap}
    function automatic logic [39:0] upd_word(input logic v, input int q, input int o, input logic w);
        return {v, 14'(q), 24'(o), w};
    endfunction

    // Issue one consume; returns at the negedge where its update report is visible.
    task automatic con(input int q, input int n, input int qd);
        @(negedge clk);
        consume_valid = 1'b1; consume_qpn = 14'(q); consume_num = 8'(n); consume_qdepth_log = 5'(qd);
        @(negedge clk);
        consume_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd(input int a, output logic [OW-1:0] d);
        @(negedge clk);
        rq_offset_addr = 14'(a);
        @(negedge clk);
        d = rq_offset_dout;
    endtask

    task automatic test_reset;
        logic [OW-1:0] d;
        logic [43:0]   outs;
        int            cyc;
        logic          rdy_seen;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        outs = {rq_offset_dout, consume_ready, clr_ready, upd_valid, upd_qpn, upd_wrap, init_done};
        n_vec++; if (outs !== '0 || upd_offset !== '0) begin n_err++; $display("FAIL reset_outputs: got %h/%h required 0", outs, upd_offset); end
        rst_n = 1'b1;
        cyc = 0; rdy_seen = 1'b0;
        while (init_done !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (init_done !== 1'b1 && (consume_ready !== 1'b0 || clr_ready !== 1'b0)) rdy_seen = 1'b1;
        end
        n_vec++; if (cyc !== 16384) begin n_err++; $display("FAIL init_latency: got %0d cycles required 16384", cyc); end
        n_vec++; if (rdy_seen !== 1'b0) begin n_err++; $display("FAIL ready_during_init: got %b required 0", rdy_seen); end
        rd(100, d);
        n_vec++; if (d !== 24'd0) begin n_err++; $display("FAIL read_after_init_100: got %0d required 0", d); end
        rd(16383, d);
        n_vec++; if (d !== 24'd0) begin n_err++; $display("FAIL read_after_init_last: got %0d required 0", d); end
    endtask

    task automatic test_consume_seq;
        logic [OW-1:0] d;
        for (int k = 1; k <= 3; k++) begin
            con(5, 4, 6);
            n_vec++;
            if ({upd_valid, upd_qpn, upd_offset, upd_wrap} !== upd_word(1'b1, 5, 4 * k, 1'b0)) begin
                n_err++; $display("FAIL consume_seq_%0d: got %h required %h", k, {upd_valid, upd_qpn, upd_offset, upd_wrap}, upd_word(1'b1, 5, 4 * k, 1'b0));
            end
        end
        rd(5, d);
        n_vec++; if (d !== 24'd12) begin n_err++; $display("FAIL consume_seq_read: got %0d required 12", d); end
    endtask

    task automatic test_wrap;
        con(5, 48, 6);
        n_vec++; if ({upd_valid, upd_qpn, upd_offset, upd_wrap} !== upd_word(1'b1, 5, 60, 1'b0)) begin
            n_err++; $display("FAIL wrap_to_60: got %h required %h", {upd_valid, upd_qpn, upd_offset, upd_wrap}, upd_word(1'b1, 5, 60, 1'b0)); end
        con(5, 8, 6);
        n_vec++; if ({upd_valid, upd_qpn, upd_offset, upd_wrap} !== upd_word(1'b1, 5, 4, 1'b1)) begin
            n_err++; $display("FAIL wrap_past_end: got %h required %h", {upd_valid, upd_qpn, upd_offset, upd_wrap}, upd_word(1'b1, 5, 4, 1'b1)); end
    endtask

    task automatic test_boundary;
        con(11, 5, 0);
        n_vec++; if ({upd_valid, upd_qpn, upd_offset, upd_wrap} !== upd_word(1'b1, 11, 0, 1'b1)) begin
            n_err++; $display("FAIL qdepth0: got %h required %h", {upd_valid, upd_qpn, upd_offset, upd_wrap}, upd_word(1'b1, 11, 0, 1'b1)); end
        con(11, 3, 4);
        n_vec++; if ({upd_valid, upd_qpn, upd_offset, upd_wrap} !== upd_word(1'b1, 11, 3, 1'b0)) begin
            n_err++; $display("FAIL qdepth4_step3: got %h required %h", {upd_valid, upd_qpn, upd_offset, upd_wrap}, upd_word(1'b1, 11, 3, 1'b0)); end
        con(11, 0, 4);
        n_vec++; if ({upd_valid, upd_qpn, upd_offset, upd_wrap} !== upd_word(1'b1, 11, 3, 1'b0)) begin
            n_err++; $display("FAIL num_zero: got %h required %h", {upd_valid, upd_qpn, upd_offset, upd_wrap}, upd_word(1'b1, 11, 3, 1'b0)); end
        con(11, 13, 4);
        n_vec++; if ({upd_valid, upd_qpn, upd_offset, upd_wrap} !== upd_word(1'b1, 11, 0, 1'b1)) begin
            n_err++; $display("FAIL exact_end: got %h required %h", {upd_valid, upd_qpn, upd_offset, upd_wrap}, upd_word(1'b1, 11, 0, 1'b1)); end
    endtask

    task automatic test_back_to_back;
        logic [OW-1:0] d;
        @(negedge clk);
        consume_valid = 1'b1; consume_qpn = 14'd7; consume_num = 8'd1; consume_qdepth_log = 5'd10;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 5) begin
                n_vec++;
                if ({upd_valid, upd_qpn, upd_offset, upd_wrap} !== upd_word(1'b1, 7, k - 1, 1'b0)) begin
                    n_err++; $display("FAIL back_to_back_%0d: got %h required %h", k - 1, {upd_valid, upd_qpn, upd_offset, upd_wrap}, upd_word(1'b1, 7, k - 1, 1'b0));
                end
            end
            if (k == 6) begin
                n_vec++; if (upd_valid !== 1'b0) begin n_err++; $display("FAIL back_to_back_extra: got %b required 0", upd_valid); end
            end
            if (k == 4) consume_valid = 1'b0;
        end
        rd(7, d);
        n_vec++; if (d !== 24'd4) begin n_err++; $display("FAIL back_to_back_read: got %0d required 4", d); end
    endtask

    task automatic test_clr_priority;
        con(9, 20, 10);
        n_vec++; if (upd_offset !== 24'd20) begin n_err++; $display("FAIL clr_setup: got %0d required 20", upd_offset); end
        @(negedge clk);
        clr_valid = 1'b1; clr_qpn = 14'd9;
        consume_valid = 1'b1; consume_qpn = 14'd9; consume_num = 8'd2; consume_qdepth_log = 5'd10;
        #1;
        n_vec++; if ({clr_ready, consume_ready} !== 2'b10) begin n_err++; $display("FAIL clr_priority_ready: got %b required 10", {clr_ready, consume_ready}); end
        @(negedge clk);
        clr_valid = 1'b0;
        #1;
        n_vec++; if (consume_ready !== 1'b1) begin n_err++; $display("FAIL consume_ready_after_clr: got %b required 1", consume_ready); end
        @(negedge clk);
        consume_valid = 1'b0;
        n_vec++; if ({upd_valid, upd_qpn, upd_offset, upd_wrap} !== upd_word(1'b1, 9, 0, 1'b0)) begin
            n_err++; $display("FAIL clr_update: got %h required %h", {upd_valid, upd_qpn, upd_offset, upd_wrap}, upd_word(1'b1, 9, 0, 1'b0)); end
        @(negedge clk);
        n_vec++; if ({upd_valid, upd_qpn, upd_offset, upd_wrap} !== upd_word(1'b1, 9, 2, 1'b0)) begin
            n_err++; $display("FAIL consume_after_clr: got %h required %h", {upd_valid, upd_qpn, upd_offset, upd_wrap}, upd_word(1'b1, 9, 2, 1'b0)); end
    endtask

    task automatic test_read_forward;
        @(negedge clk);
        consume_valid = 1'b1; consume_qpn = 14'd3; consume_num = 8'd17; consume_qdepth_log = 5'd10;
        @(negedge clk);
        consume_valid = 1'b0;
        rq_offset_addr = 14'd3;
        @(negedge clk);
        n_vec++; if (rq_offset_dout !== 24'd17) begin n_err++; $display("FAIL read_forward: got %0d required 17", rq_offset_dout); end
        n_vec++; if (upd_offset !== 24'd17) begin n_err++; $display("FAIL read_forward_upd: got %0d required 17", upd_offset); end
    endtask

    task automatic test_reset_inflight;
        logic [OW-1:0] d;
        logic [43:0]   outs;
        logic          pulse_seen;
        int            cyc;
        @(negedge clk);
        consume_valid = 1'b1; consume_qpn = 14'd12; consume_num = 8'd5; consume_qdepth_log = 5'd10;
        @(negedge clk);
        consume_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        outs = {rq_offset_dout, consume_ready, clr_ready, upd_valid, upd_qpn, upd_wrap, init_done};
        n_vec++; if (outs !== '0 || upd_offset !== '0) begin n_err++; $display("FAIL inflight_reset_outputs: got %h/%h required 0", outs, upd_offset); end
        pulse_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (upd_valid !== 1'b0) pulse_seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (upd_valid !== 1'b0) pulse_seen = 1'b1;
        end
        n_vec++; if (pulse_seen !== 1'b0) begin n_err++; $display("FAIL inflight_upd_pulse: got %b required 0", pulse_seen); end
        n_vec++; if ({init_done, clr_ready, consume_ready} !== 3'b000) begin
            n_err++; $display("FAIL reenter_init: got %b required 000", {init_done, clr_ready, consume_ready}); end
        cyc = 0;
        while (init_done !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++; if (init_done !== 1'b1) begin n_err++; $display("FAIL reinit_timeout: got %b required 1", init_done); end
        rd(12, d);
        n_vec++; if (d !== 24'd0) begin n_err++; $display("FAIL inflight_no_write: got %0d required 0", d); end
        rd(5, d);
        n_vec++; if (d !== 24'd0) begin n_err++; $display("FAIL resweep_clears: got %0d required 0", d); end
    endtask

    initial begin
        test_reset();
        test_consume_seq();
        test_wrap();
        test_boundary();
        test_back_to_back();
        test_clr_priority();
        test_read_forward();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got %0d miscompares so far, required completion", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
